ps2_keyboard: RTL and testbench

PS2_KEYBOARD -- requirements
Module: ps2_keyboard

---
 rtl/ps2_keyboard_if.sv | 28 ++
 rtl/ps2_keyboard.sv | 216 +++++++++++++++++++++
 tb/tb_ps2_keyboard.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_keyboard_if.sv
// Keyboard-side bundle: raw PS/2 lines in, decoded key state and event pulses out.
// The slave modport is the decoder's view; the master modport is the keyboard/game side.
interface ps2_keyboard_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] key_code;
  logic       key_extended;
  logic       key_valid;
  logic       frame_error;

  modport slave (
    input  ps2_clk,
    input  ps2_data,
    output key_code,
    output key_extended,
    output key_valid,
    output frame_error
  );

  modport master (
    output ps2_clk,
    output ps2_data,
    input  key_code,
    input  key_extended,
    input  key_valid,
    input  frame_error
  );
endinterface

// File: rtl/ps2_keyboard.sv
// PS/2 keyboard receiver: synchronizes and de-glitches the keyboard clock, frames 11-bit
// words, and turns make/break/E0 scan-code sequences into a held key code.
module ps2_keyboard #(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic          clock,
  input  logic          reset_signal,
  ps2_keyboard_if.slave bus
);

  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN + 1) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  function automatic logic f_odd_parity_ok(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction

  logic [1:0]    r_clk_sync;
  logic [1:0]    r_data_sync;
  logic          r_filt_clk;
  logic          r_filt_prev;
  logic [FW-1:0] r_filt_cnt;
  state_t        r_state;
  logic [7:0]    r_shift;
  logic [2:0]    r_bit_cnt;
  logic          r_par_ok;
  logic [TW-1:0] r_to_cnt;
  logic          r_ext_pend;
  logic          r_brk_pend;
  logic [7:0]    r_key_code;
  logic          r_key_ext;
  logic          r_key_valid;
  logic          r_frame_err;

  state_t        w_state_nx;
  logic [7:0]    w_shift_nx;
  logic [2:0]    w_bit_cnt_nx;
  logic          w_par_ok_nx;
  logic [TW-1:0] w_to_cnt_nx;
  logic          w_byte_ok;
  logic          w_frame_err;
  logic          w_fall;
  logic          w_bit;
  logic          w_timeout;

  assign w_fall    = r_filt_prev & ~r_filt_clk;
  assign w_bit     = r_data_sync[1];
  assign w_timeout = (r_state != S_IDLE) && !w_fall && (r_to_cnt == TO_LAST);

  // Synchronizers and ps2_clk level filter; everything idles high.
  always_ff @(posedge clock or negedge reset_signal) begin
    if (!reset_signal) begin
      r_clk_sync  <= 2'b11;
      r_data_sync <= 2'b11;
      r_filt_clk  <= 1'b1;
      r_filt_prev <= 1'b1;
      r_filt_cnt  <= '0;
    end else begin
      r_clk_sync  <= {r_clk_sync[0], bus.ps2_clk};
      r_data_sync <= {r_data_sync[0], bus.ps2_data};
      r_filt_prev <= r_filt_clk;
      if (r_clk_sync[1] == r_filt_clk) begin
        r_filt_cnt <= '0;
      end else if (r_filt_cnt == FILT_LAST) begin
        r_filt_clk <= r_clk_sync[1];
        r_filt_cnt <= '0;
      end else begin
        r_filt_cnt <= r_filt_cnt + 1'b1;
      end
    end
  end

  // Frame state and datapath registers.
  always_ff @(posedge clock or negedge reset_signal) begin
    if (!reset_signal) begin
      r_state   <= S_IDLE;
      r_shift   <= 8'h00;
      r_bit_cnt <= 3'd0;
      r_par_ok  <= 1'b0;
      r_to_cnt  <= '0;
    end else begin
      r_state   <= w_state_nx;
      r_shift   <= w_shift_nx;
      r_bit_cnt <= w_bit_cnt_nx;
      r_par_ok  <= w_par_ok_nx;
      r_to_cnt  <= w_to_cnt_nx;
    end
  end

  // Mid-frame idle counter; cleared on every clock edge and whenever idle.
  always_comb begin
    if ((r_state == S_IDLE) || w_fall || w_timeout) begin
      w_to_cnt_nx = '0;
    end else begin
      w_to_cnt_nx = r_to_cnt + 1'b1;
    end
  end

  // Frame FSM next state; acts only on filtered falling edges or timeout.
  always_comb begin
    w_state_nx   = r_state;
    w_shift_nx   = r_shift;
    w_bit_cnt_nx = r_bit_cnt;
    w_par_ok_nx  = r_par_ok;
    w_byte_ok    = 1'b0;
    w_frame_err  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_fall && !w_bit) begin
          w_state_nx   = S_DATA;
          w_bit_cnt_nx = 3'd0;
        end else begin
          w_state_nx = S_IDLE;
        end
      end
      S_DATA: begin
        if (w_fall) begin
          w_shift_nx   = {w_bit, r_shift[7:1]};
          w_bit_cnt_nx = r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) begin
            w_state_nx = S_PARITY;
          end else begin
            w_state_nx = S_DATA;
          end
        end else if (w_timeout) begin
          w_state_nx  = S_IDLE;
          w_frame_err = 1'b1;
        end else begin
          w_state_nx = S_DATA;
        end
      end
      S_PARITY: begin
        if (w_fall) begin
          w_par_ok_nx = f_odd_parity_ok(r_shift, w_bit);
          w_state_nx  = S_STOP;
        end else if (w_timeout) begin
          w_state_nx  = S_IDLE;
          w_frame_err = 1'b1;
        end else begin
          w_state_nx = S_PARITY;
        end
      end
      S_STOP: begin
        if (w_fall) begin
          w_state_nx = S_IDLE;
          if (w_bit && r_par_ok) begin
            w_byte_ok = 1'b1;
          end else begin
            w_frame_err = 1'b1;
          end
        end else if (w_timeout) begin
          w_state_nx  = S_IDLE;
          w_frame_err = 1'b1;
        end else begin
          w_state_nx = S_STOP;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  // Scan-code decoder: E0/F0 prefixes arm flags, other bytes make or break the held key.
  always_ff @(posedge clock or negedge reset_signal) begin
    if (!reset_signal) begin
      r_ext_pend  <= 1'b0;
      r_brk_pend  <= 1'b0;
      r_key_code  <= 8'h00;
      r_key_ext   <= 1'b0;
      r_key_valid <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_key_valid <= 1'b0;
      r_frame_err <= w_frame_err;
      if (w_byte_ok) begin
        if (r_shift == 8'hE0) begin
          r_ext_pend <= 1'b1;
        end else if (r_shift == 8'hF0) begin
          r_brk_pend <= 1'b1;
        end else begin
          r_ext_pend <= 1'b0;
          r_brk_pend <= 1'b0;
          if (!r_brk_pend) begin
            r_key_code  <= r_shift;
            r_key_ext   <= r_ext_pend;
            r_key_valid <= 1'b1;
          end else if ((r_shift == r_key_code) && (r_ext_pend == r_key_ext)) begin
            r_key_code <= 8'h00;
            r_key_ext  <= 1'b0;
          end else begin
            r_key_code <= r_key_code;
          end
        end
      end else begin
        r_key_code <= r_key_code;
      end
    end
  end

  assign bus.key_code     = r_key_code;
  assign bus.key_extended = r_key_ext;
  assign bus.key_valid    = r_key_valid;
  assign bus.frame_error  = r_frame_err;

endmodule

// File: tb/tb_ps2_keyboard.sv
// Bench for ps2_keyboard: directed vector table, hand-written corner sequences, then
// random frames checked against a scan-code model.
module tb_ps2_keyboard;
  localparam int HALF = 15;
  localparam int GAP  = 20;
  localparam int TO   = 400;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  ps2_keyboard_if bus();

  ps2_keyboard #(.FILTER_LEN(4), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clk),
    .reset_signal(rst_n),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int fall_cyc = 0;
  int last_valid_cyc = 0;
  int n_valid = 0;
  int n_err = 0;
  int n_both = 0;
  int n_consec = 0;
  logic prev_v = 1'b0;
  logic prev_e = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.key_valid) begin
      n_valid <= n_valid + 1;
      last_valid_cyc <= cyc;
    end
    if (bus.frame_error) n_err <= n_err + 1;
    if (bus.key_valid && bus.frame_error) n_both <= n_both + 1;
    if ((bus.key_valid && prev_v) || (bus.frame_error && prev_e)) n_consec <= n_consec + 1;
    prev_v <= bus.key_valid;
    prev_e <= bus.frame_error;
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    bus.ps2_data = b;
    wait_cyc(HALF);
    bus.ps2_clk = 1'b0;
    fall_cyc = cyc;
    wait_cyc(HALF);
    bus.ps2_clk = 1'b1;
  endtask

  // nbits < 11 truncates the frame; glitch_at >= 0 inserts a 1-cycle low pulse before that bit.
  task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic bad_stop,
                            input int nbits, input int glitch_at);
    logic [10:0] fr;
    fr = {~bad_stop, (~^d) ^ bad_par, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      if (i == glitch_at) begin
        wait_cyc(HALF);
        bus.ps2_clk = 1'b0;
        wait_cyc(1);
        bus.ps2_clk = 1'b1;
      end
      send_bit(fr[i]);
    end
    bus.ps2_data = 1'b1;
    wait_cyc(GAP);
  endtask

  task automatic run_frame(input string name, input logic [7:0] d, input logic bp, input logic bs,
                           input logic [7:0] e_code, input logic e_ext, input int e_v, input int e_e);
    int v0, e0;
    v0 = n_valid;
    e0 = n_err;
    send_frame(d, bp, bs, 11, -1);
    check({name, " code"}, int'(bus.key_code), int'(e_code));
    check({name, " ext"}, int'(bus.key_extended), int'(e_ext));
    check({name, " valid"}, n_valid - v0, e_v);
    check({name, " err"}, n_err - e0, e_e);
  endtask

  typedef struct {
    logic [7:0] d;
    logic       bp;
    logic       bs;
    logic [7:0] code;
    logic       ext;
    int         v;
    int         e;
  } vec_t;

  vec_t tbl[17];

  // Scan-code model state
  logic [7:0] m_code;
  logic       m_ext, m_extp, m_brkp;

  task automatic model_apply(input logic [7:0] d, input logic good, output int ev, output int ee);
    ev = 0;
    ee = good ? 0 : 1;
    if (good) begin
      if (d == 8'hE0) m_extp = 1'b1;
      else if (d == 8'hF0) m_brkp = 1'b1;
      else begin
        if (!m_brkp) begin
          m_code = d;
          m_ext = m_extp;
          ev = 1;
        end else if (d == m_code && m_extp == m_ext) begin
          m_code = 8'h00;
          m_ext = 1'b0;
        end
        m_extp = 1'b0;
        m_brkp = 1'b0;
      end
    end
  endtask

  initial begin
    int v0, e0, lat, ev, ee;
    logic [7:0] pool [6];
    logic [7:0] d;
    logic bp, bs;

    tbl[0]  = '{8'h3C, 1'b0, 1'b0, 8'h3C, 1'b1 & 1'b0, 1, 0};
    tbl[1]  = '{8'hF0, 1'b0, 1'b0, 8'h3C, 1'b0, 0, 0};
    tbl[2]  = '{8'h3C, 1'b0, 1'b0, 8'h00, 1'b0, 0, 0};
    tbl[3]  = '{8'hE0, 1'b0, 1'b0, 8'h00, 1'b0, 0, 0};
    tbl[4]  = '{8'h75, 1'b0, 1'b0, 8'h75, 1'b1, 1, 0};
    tbl[5]  = '{8'hF0, 1'b0, 1'b0, 8'h75, 1'b1, 0, 0};
    tbl[6]  = '{8'h75, 1'b0, 1'b0, 8'h75, 1'b1, 0, 0};
    tbl[7]  = '{8'hE0, 1'b0, 1'b0, 8'h75, 1'b1, 0, 0};
    tbl[8]  = '{8'hF0, 1'b0, 1'b0, 8'h75, 1'b1, 0, 0};
    tbl[9]  = '{8'h75, 1'b0, 1'b0, 8'h00, 1'b0, 0, 0};
    tbl[10] = '{8'h1C, 1'b1, 1'b0, 8'h00, 1'b0, 0, 1};
    tbl[11] = '{8'h1C, 1'b0, 1'b0, 8'h1C, 1'b0, 1, 0};
    tbl[12] = '{8'h1C, 1'b0, 1'b0, 8'h1C, 1'b0, 1, 0};
    tbl[13] = '{8'h2B, 1'b0, 1'b1, 8'h1C, 1'b0, 0, 1};
    tbl[14] = '{8'hE0, 1'b0, 1'b0, 8'h1C, 1'b0, 0, 0};
    tbl[15] = '{8'h5A, 1'b1, 1'b0, 8'h1C, 1'b0, 0, 1};
    tbl[16] = '{8'h5A, 1'b0, 1'b0, 8'h5A, 1'b1, 1, 0};

    bus.ps2_clk = 1'b1;
    bus.ps2_data = 1'b1;
    wait_cyc(3);
    check("reset code", int'(bus.key_code), 0);
    check("reset ext", int'(bus.key_extended), 0);
    check("reset valid", int'(bus.key_valid), 0);
    check("reset err", int'(bus.frame_error), 0);
    rst_n = 1'b1;
    wait_cyc(10);

    for (int i = 0; i < 17; i++) begin
      run_frame($sformatf("row%0d", i), tbl[i].d, tbl[i].bp, tbl[i].bs,
                tbl[i].code, tbl[i].ext, tbl[i].v, tbl[i].e);
    end

    // Latency from stop-bit falling edge to key_valid
    run_frame("lat16", 8'h16, 1'b0, 1'b0, 8'h16, 1'b0, 1, 0);
    lat = last_valid_cyc - fall_cyc;
    check("latency window", int'(lat >= 5 && lat <= 9), 1);

    // Clock stalls after five bits
    v0 = n_valid;
    e0 = n_err;
    send_frame(8'h33, 1'b0, 1'b0, 5, -1);
    wait_cyc(TO + 100);
    check("timeout err", n_err - e0, 1);
    check("timeout valid", n_valid - v0, 0);
    check("timeout code", int'(bus.key_code), 8'h16);
    run_frame("post-timeout", 8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0, 1, 0);

    // One-cycle glitches: mid-frame and while idle
    v0 = n_valid;
    e0 = n_err;
    send_frame(8'h29, 1'b0, 1'b0, 11, 4);
    bus.ps2_clk = 1'b0;
    wait_cyc(1);
    bus.ps2_clk = 1'b1;
    wait_cyc(GAP);
    check("glitch code", int'(bus.key_code), 8'h29);
    check("glitch valid", n_valid - v0, 1);
    check("glitch err", n_err - e0, 0);

    // Reset in the middle of a frame
    send_frame(8'h12, 1'b0, 1'b0, 4, -1);
    rst_n = 1'b0;
    wait_cyc(2);
    check("midreset code", int'(bus.key_code), 0);
    check("midreset ext", int'(bus.key_extended), 0);
    check("midreset valid", int'(bus.key_valid), 0);
    check("midreset err", int'(bus.frame_error), 0);
    rst_n = 1'b1;
    wait_cyc(10);
    run_frame("post-reset", 8'h44, 1'b0, 1'b0, 8'h44, 1'b0, 1, 0);

    // Random frames against the model, from a fresh reset
    rst_n = 1'b0;
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(10);
    m_code = 8'h00;
    m_ext = 1'b0;
    m_extp = 1'b0;
    m_brkp = 1'b0;
    pool[0] = 8'hE0; pool[1] = 8'hF0; pool[2] = 8'h1C;
    pool[3] = 8'h3C; pool[4] = 8'h75; pool[5] = 8'h5A;
    for (int k = 0; k < 40; k++) begin
      int sel;
      sel = int'($urandom_range(0, 7));
      if (sel < 6) d = pool[sel];
      else d = 8'($urandom_range(0, 255));
      bp = ($urandom_range(0, 9) == 0);
      bs = ($urandom_range(0, 14) == 0);
      model_apply(d, !(bp || bs), ev, ee);
      run_frame($sformatf("rnd%0d_%02h", k, d), d, bp, bs, m_code, m_ext, ev, ee);
    end

    check("valid&err same cycle", n_both, 0);
    check("back-to-back pulse", n_consec, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
